// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared constants for the RC4 key-search sequencer
package rc4_pkg;

    localparam logic [7:0] CHAR_A  = 8'd97;
    localparam logic [7:0] CHAR_Z  = 8'd122;
    localparam logic [7:0] CHAR_SP = 8'd32;

    localparam int MSG_LEN_DEFAULT = 32;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_LAUNCH     = 4'd1;
    localparam logic [3:0] ST_WAIT_CHAIN = 4'd2;
    localparam logic [3:0] ST_RD_ADDR    = 4'd3;
    localparam logic [3:0] ST_RD_WAIT    = 4'd4;
    localparam logic [3:0] ST_CHECK      = 4'd5;
    localparam logic [3:0] ST_NEXT_KEY   = 4'd6;
    localparam logic [3:0] ST_FOUND      = 4'd7;
    localparam logic [3:0] ST_FAIL       = 4'd8;

endpackage

// File: rtl/plaintext_char_check.sv
// rtl/plaintext_char_check.sv - combinational test for a printable plaintext byte
module plaintext_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       char_ok
);

    assign char_ok = ((char_in >= CHAR_A) && (char_in <= CHAR_Z)) || (char_in == CHAR_SP);

endmodule

// File: rtl/key_search_ctrl.sv
// rtl/key_search_ctrl.sv - brute-force key sequencer driving the RC4 decrypt chain
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int KEY_W     = 24,
    parameter int SEARCH_W  = 22,
    parameter int KEY_START = 0,
    parameter int KEY_STEP  = 1,
    parameter int MSG_LEN   = MSG_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [KEY_W-1:0] key_out,
    output logic             chain_start,
    input  logic             chain_done,
    output logic             dm_sel,
    output logic [7:0]       dm_addr,
    input  logic [7:0]       dm_rddata,
    output logic             busy,
    output logic             found,
    output logic             fail
);

    localparam logic [7:0]       LAST_ADDR = 8'(MSG_LEN - 1);
    localparam logic [KEY_W-1:0] KEY_FIRST = KEY_W'(KEY_START);

    logic [3:0]        state;
    logic              char_ok;
    logic [SEARCH_W:0] step_sum;
    logic [KEY_W-1:0]  key_next;

    plaintext_char_check u_char_check (
        .char_in (dm_rddata),
        .char_ok (char_ok)
    );

    // One extra bit catches overflow of the searched field instead of wrapping.
    assign step_sum = {1'b0, key_out[SEARCH_W-1:0]} + (SEARCH_W+1)'(KEY_STEP);
    assign key_next = KEY_W'(step_sum[SEARCH_W-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            key_out     <= KEY_FIRST;
            chain_start <= 1'b0;
            dm_sel      <= 1'b0;
            dm_addr     <= 8'd0;
            busy        <= 1'b0;
            found       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            chain_start <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                dm_sel <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            key_out     <= KEY_FIRST;
                            found       <= 1'b0;
                            fail        <= 1'b0;
                            busy        <= 1'b1;
                            chain_start <= 1'b1;
                            state       <= ST_LAUNCH;
                        end
                    end
                    ST_LAUNCH: state <= ST_WAIT_CHAIN;
                    ST_WAIT_CHAIN: begin
                        if (chain_done) begin
                            dm_sel  <= 1'b1;
                            dm_addr <= 8'd0;
                            state   <= ST_RD_ADDR;
                        end
                    end
                    ST_RD_ADDR: state <= ST_RD_WAIT;
                    ST_RD_WAIT: state <= ST_CHECK;
                    ST_CHECK: begin
                        if (!char_ok) begin
                            state <= ST_NEXT_KEY;
                        end else if (dm_addr == LAST_ADDR) begin
                            found  <= 1'b1;
                            busy   <= 1'b0;
                            dm_sel <= 1'b0;
                            state  <= ST_FOUND;
                        end else begin
                            dm_addr <= dm_addr + 8'd1;
                            state   <= ST_RD_ADDR;
                        end
                    end
                    ST_NEXT_KEY: begin
                        dm_sel <= 1'b0;
                        if (step_sum[SEARCH_W]) begin
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FAIL;
                        end else begin
                            key_out     <= key_next;
                            chain_start <= 1'b1;
                            state       <= ST_LAUNCH;
                        end
                    end
                    ST_FOUND: state <= ST_IDLE;
                    ST_FAIL:  state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb/tb_key_search_ctrl.sv - directed self-checking bench for key_search_ctrl
module tb_key_search_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          failures = 0;

    logic        a_start = 1'b0, a_abort = 1'b0, a_chain_done = 1'b0;
    logic [7:0]  a_dm_rddata = 8'd0, a_dm_addr;
    logic [23:0] a_key_out;
    logic        a_chain_start, a_dm_sel, a_busy, a_found, a_fail;

    logic        b_start = 1'b0, b_abort = 1'b0, b_chain_done = 1'b0;
    logic [7:0]  b_dm_rddata = 8'd0, b_dm_addr;
    logic [23:0] b_key_out;
    logic        b_chain_start, b_dm_sel, b_busy, b_found, b_fail;

    int          a_mode = 0;
    int          a_launches = 0, b_launches = 0;
    int          a_cnt = 0, b_cnt = 0;
    logic [23:0] a_keys[$];
    logic [23:0] b_keys[$];

    always #5 clk = ~clk;

    key_search_ctrl #(.KEY_W(24), .SEARCH_W(3), .KEY_START(0), .KEY_STEP(1), .MSG_LEN(32)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .key_out(a_key_out), .chain_start(a_chain_start), .chain_done(a_chain_done),
        .dm_sel(a_dm_sel), .dm_addr(a_dm_addr), .dm_rddata(a_dm_rddata),
        .busy(a_busy), .found(a_found), .fail(a_fail)
    );

    key_search_ctrl #(.KEY_W(24), .SEARCH_W(3), .KEY_START(1), .KEY_STEP(2), .MSG_LEN(32)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .key_out(b_key_out), .chain_start(b_chain_start), .chain_done(b_chain_done),
        .dm_sel(b_dm_sel), .dm_addr(b_dm_addr), .dm_rddata(b_dm_rddata),
        .busy(b_busy), .found(b_found), .fail(b_fail)
    );

    // Key 3: 'a','z',' ','q' pattern; key 2: valid until '{' at byte 31; key 1: '`'; else 0.
    function automatic logic [7:0] dm_a(input logic [7:0] addr, input logic [23:0] key);
        logic [7:0] pat [4];
        pat[0] = 8'd97; pat[1] = 8'd122; pat[2] = 8'd32; pat[3] = 8'd113;
        case (key)
            24'd3:   return pat[addr[1:0]];
            24'd2:   return (addr == 8'd31) ? 8'd123 : 8'd97;
            24'd1:   return 8'd96;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        a_dm_rddata <= (a_mode == 0) ? 8'd0 : dm_a(a_dm_addr, a_key_out);
        b_dm_rddata <= 8'd123;
    end

    always @(negedge clk) begin
        if (a_chain_start) begin a_launches++; a_keys.push_back(a_key_out); a_cnt = 4; end
        else if (a_cnt > 0) a_cnt--;
        a_chain_done = (a_cnt == 1);
        if (b_chain_start) begin b_launches++; b_keys.push_back(b_key_out); b_cnt = 4; end
        else if (b_cnt > 0) b_cnt--;
        b_chain_done = (b_cnt == 1);
    end

    task automatic pulse_start(input bit sel_b, input bit with_abort);
        @(negedge clk); #1;
        if (sel_b) begin b_start = 1'b1; b_abort = with_abort; end
        else begin a_start = 1'b1; a_abort = with_abort; end
        @(negedge clk); #1;
        a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b, input int budget, input string tag);
        int n = 0;
        while ((sel_b ? b_busy : a_busy) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if ((sel_b ? b_busy : a_busy) !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout busy still 1 after %0d cycles, required 0", tag, budget);
        end
    endtask

    task automatic test_reset;
        int base;
        @(negedge clk); #1;
        checks++;
        if ({a_key_out, a_chain_start, a_dm_sel, a_dm_addr, a_busy, a_found, a_fail} !== {24'd0, 13'd0}) begin
            failures++;
            $display("FAIL reset_a got key=%0d cs=%b sel=%b addr=%0d busy=%b found=%b fail=%b, required all 0",
                     a_key_out, a_chain_start, a_dm_sel, a_dm_addr, a_busy, a_found, a_fail);
        end
        checks++;
        if ({b_key_out, b_busy, b_found, b_fail, b_dm_sel} !== {24'd1, 4'd0}) begin
            failures++;
            $display("FAIL reset_b got key=%0d busy=%b, required key=1 busy=0", b_key_out, b_busy);
        end
        reset = 1'b0;
        pulse_start(1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        base = a_launches;
        checks++;
        if ({a_key_out, a_chain_start, a_dm_sel, a_dm_addr, a_busy, a_found, a_fail} !== {24'd0, 13'd0}) begin
            failures++;
            $display("FAIL reset_mid_wait got key=%0d cs=%b sel=%b busy=%b, required all 0",
                     a_key_out, a_chain_start, a_dm_sel, a_busy);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (a_launches != base || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_launch got launches=%0d busy=%b, required %0d and 0", a_launches, a_busy, base);
        end
    endtask

    task automatic test_hit_key3;
        int idx = a_keys.size();
        int n0 = a_launches;
        a_mode = 1;
        pulse_start(1'b0, 1'b0);
        wait_idle(1'b0, 3000, "hit");
        checks++;
        if (a_launches - n0 != 4 || a_keys.size() - idx != 4) begin
            failures++;
            $display("FAIL hit_launches got %0d, required 4", a_launches - n0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (a_keys[idx + k] !== 24'(k)) begin
                    failures++;
                    $display("FAIL hit_key_seq[%0d] got %0d, required %0d", k, a_keys[idx + k], k);
                end
            end
        end
        checks++;
        if ({a_found, a_fail, a_dm_sel} !== 3'b100 || a_key_out !== 24'd3) begin
            failures++;
            $display("FAIL hit_result got found=%b fail=%b sel=%b key=%0d, required 1 0 0 key=3",
                     a_found, a_fail, a_dm_sel, a_key_out);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (a_found !== 1'b1 || a_key_out !== 24'd3) begin
            failures++;
            $display("FAIL hit_sticky got found=%b key=%0d, required 1 key=3", a_found, a_key_out);
        end
    endtask

    task automatic test_early_reject;
        int n0 = a_launches;
        int sel_cycles = 0;
        int max_addr = 0;
        int n = 0;
        a_mode = 1;
        pulse_start(1'b0, 1'b0);
        while (a_launches < n0 + 2 && n < 200) begin
            @(negedge clk); #1;
            if (a_dm_sel) begin
                sel_cycles++;
                if (int'(a_dm_addr) > max_addr) max_addr = int'(a_dm_addr);
            end
            n++;
        end
        checks++;
        if (a_launches < n0 + 2) begin
            failures++;
            $display("FAIL reject_timeout got launches=%0d, required %0d", a_launches - n0, 2);
        end
        checks++;
        if (max_addr != 0 || sel_cycles < 3 || sel_cycles > 4) begin
            failures++;
            $display("FAIL reject_one_read got max_addr=%0d sel_cycles=%0d, required 0 and 3..4", max_addr, sel_cycles);
        end
        checks++;
        if (a_key_out !== 24'd1 || a_found !== 1'b0) begin
            failures++;
            $display("FAIL reject_next_key got key=%0d found=%b, required key=1 found=0", a_key_out, a_found);
        end
        a_abort = 1'b1;
        @(negedge clk); #1;
        a_abort = 1'b0;
    endtask

    task automatic test_exhaust;
        int n0 = a_launches;
        a_mode = 0;
        pulse_start(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        pulse_start(1'b0, 1'b0);
        wait_idle(1'b0, 1000, "exhaust");
        checks++;
        if (a_launches - n0 != 8) begin
            failures++;
            $display("FAIL exhaust_launches got %0d, required 8", a_launches - n0);
        end
        checks++;
        if ({a_fail, a_found, a_dm_sel} !== 3'b100 || a_key_out !== 24'd7) begin
            failures++;
            $display("FAIL exhaust_result got fail=%b found=%b sel=%b key=%0d, required 1 0 0 key=7",
                     a_fail, a_found, a_dm_sel, a_key_out);
        end
    endtask

    task automatic test_partition;
        int idx = b_keys.size();
        pulse_start(1'b1, 1'b0);
        wait_idle(1'b1, 1000, "partition");
        checks++;
        if (b_keys.size() - idx != 4) begin
            failures++;
            $display("FAIL partition_launches got %0d, required 4", b_keys.size() - idx);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (b_keys[idx + k] !== 24'(2 * k + 1)) begin
                    failures++;
                    $display("FAIL partition_key[%0d] got %0d, required %0d", k, b_keys[idx + k], 2 * k + 1);
                end
            end
        end
        checks++;
        if ({b_fail, b_found} !== 2'b10 || b_key_out !== 24'd7) begin
            failures++;
            $display("FAIL partition_result got fail=%b found=%b key=%0d, required 1 0 key=7", b_fail, b_found, b_key_out);
        end
    endtask

    task automatic test_abort;
        int n = 0;
        int base;
        a_mode = 0;
        pulse_start(1'b0, 1'b0);
        while (!(a_dm_sel && a_key_out == 24'd1) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!(a_dm_sel && a_key_out == 24'd1)) begin
            failures++;
            $display("FAIL abort_timeout got sel=%b key=%0d, required sel=1 key=1", a_dm_sel, a_key_out);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        a_abort = 1'b1;
        @(negedge clk); #1;
        a_abort = 1'b0;
        base = a_launches;
        checks++;
        if ({a_busy, a_dm_sel, a_found, a_fail} !== 4'b0000 || a_key_out !== 24'd1) begin
            failures++;
            $display("FAIL abort_check got busy=%b sel=%b found=%b fail=%b key=%0d, required 0 0 0 0 key=1",
                     a_busy, a_dm_sel, a_found, a_fail, a_key_out);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (a_launches != base || a_key_out !== 24'd1) begin
            failures++;
            $display("FAIL abort_stays_idle got launches=%0d key=%0d, required %0d key=1", a_launches, a_key_out, base);
        end
        pulse_start(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_launches != base) begin
            failures++;
            $display("FAIL start_with_abort got busy=%b launches=%0d, required 0 and %0d", a_busy, a_launches, base);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_hit_key3;
        test_early_reject;
        test_exhaust;
        test_partition;
        test_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
